// File: rtl/maze_pkg.sv
// Shared maze constants: direction encoding, playfield/tile geometry and the wall map.
package maze_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int TILE      = 32;
    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    // Border ring plus a pillar in every tile whose col and row are both 3 mod 4.
    function automatic logic is_wall(input int col, input int row);
        return (col == 0) || (col == GRID_COLS - 1) ||
               (row == 0) || (row == GRID_ROWS - 1) ||
               (((col & 3) == 3) && ((row & 3) == 3));
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Free-running 32-bit counter; its upper bits serve as slow strobes for the movers.
module clock_divider (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] clkdiv
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clkdiv <= 32'd0;
        else
            clkdiv <= clkdiv + 32'd1;
    end

endmodule

// File: rtl/maze_collision_check.sv
// Registered free/blocked decision for a one-pixel sprite step, plus the shared clock divider.
module maze_collision_check
    import maze_pkg::*;
#(
    parameter int SPRITE   = 16,
    parameter int TILE_PX  = TILE,
    parameter int SCR_W    = SCREEN_W,
    parameter int SCR_H    = SCREEN_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  PacX,
    input  logic [8:0]  PacY,
    input  logic [1:0]  state,
    output logic        result,
    output logic [31:0] clkdiv
);

    localparam int         TILE_SH = $clog2(TILE_PX);
    localparam logic [10:0] SPR_X  = 11'(SPRITE - 1);
    localparam logic [9:0]  SPR_Y  = 10'(SPRITE - 1);
    localparam logic [10:0] LIM_X  = 11'(SCR_W);
    localparam logic [9:0]  LIM_Y  = 10'(SCR_H);

    logic [10:0] nx, x1;
    logic [9:0]  ny, y1;
    logic        under;
    logic        in_bounds;
    logic        free;

    clock_divider u_div (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv)
    );

    // Widened step so that moving off the top/left edge is flagged instead of wrapping.
    always_comb begin
        nx    = {1'b0, PacX};
        ny    = {1'b0, PacY};
        under = 1'b0;
        case (state)
            DIR_UP:    if (PacY == 9'd0)  under = 1'b1; else ny = ny - 10'd1;
            DIR_DOWN:  ny = ny + 10'd1;
            DIR_LEFT:  if (PacX == 10'd0) under = 1'b1; else nx = nx - 11'd1;
            default:   nx = nx + 11'd1;
        endcase
    end

    assign x1        = nx + SPR_X;
    assign y1        = ny + SPR_Y;
    assign in_bounds = (x1 < LIM_X) && (y1 < LIM_Y);

    always_comb begin
        free = !under && in_bounds &&
               !is_wall(int'(nx >> TILE_SH), int'(ny >> TILE_SH)) &&
               !is_wall(int'(x1 >> TILE_SH), int'(ny >> TILE_SH)) &&
               !is_wall(int'(nx >> TILE_SH), int'(y1 >> TILE_SH)) &&
               !is_wall(int'(x1 >> TILE_SH), int'(y1 >> TILE_SH));
    end

    // Reset to blocked so a mover chooses a direction before its first step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result <= 1'b0;
        else
            result <= free;
    end

endmodule

// File: tb/tb_maze_collision_check.sv
// Randomized check of maze_collision_check against a per-pixel model of the sprite box.
module tb_maze_collision_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  PacX = 10'd45;
    logic [8:0]  PacY = 9'd45;
    logic [1:0]  state = 2'b01;
    logic        result;
    logic [31:0] clkdiv;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  check_en = 1'b0;
    logic        exp_res;
    logic [31:0] exp_div;

    maze_collision_check dut (
        .clk    (clk),
        .rst    (rst),
        .PacX   (PacX),
        .PacY   (PacY),
        .state  (state),
        .result (result),
        .clkdiv (clkdiv)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit tb_wall(int c, int r);
        return c == 0 || c == 19 || r == 0 || r == 14 || (c % 4 == 3 && r % 4 == 3);
    endfunction

    // Every pixel of the stepped 16x16 box must be on screen and outside any wall tile.
    function automatic bit model_free(int px, int py, int st);
        int nx = px;
        int ny = py;
        case (st)
            0: ny = py - 1;
            1: ny = py + 1;
            2: nx = px - 1;
            default: nx = px + 1;
        endcase
        if (nx < 0 || ny < 0) return 1'b0;
        for (int dx = 0; dx < 16; dx++)
            for (int dy = 0; dy < 16; dy++) begin
                if (nx + dx >= 640 || ny + dy >= 480) return 1'b0;
                if (tb_wall((nx + dx) / 32, (ny + dy) / 32)) return 1'b0;
            end
        return 1'b1;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_res <= 1'b0;
            exp_div <= 32'd0;
        end else begin
            exp_res <= model_free(int'(PacX), int'(PacY), int'(state));
            exp_div <= exp_div + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("result_cycle", result, exp_res);
            check("clkdiv_cycle", clkdiv, exp_div);
        end
    end

    task automatic directed(string name, int px, int py, int st, bit expv);
        @(negedge clk);
        #1;
        PacX  = 10'(px);
        PacY  = 9'(py);
        state = 2'(st);
        check({name, "_model"}, model_free(px, py, st), expv);
        @(posedge clk);
        #1;
        check(name, result, expv);
    endtask

    initial begin
        int edges;
        repeat (3) @(negedge clk);
        check("reset_result", result, 0);
        check("reset_clkdiv", clkdiv, 0);
        check_en = 1'b1;
        #1 rst = 1'b0;

        edges = 0;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("clkdiv_first", clkdiv, 1);
            if (clkdiv[9]) begin
                edges = i;
                break;
            end
        end
        check("bit9_first_rise", edges, 512);

        directed("down_open",     45,   45, 1, 1'b1);
        directed("up_border",     45,   32, 0, 1'b0);
        directed("left_border",   32,   32, 2, 1'b0);
        directed("left_zero",      0,   45, 2, 1'b0);
        directed("up_zero",       45,    0, 0, 1'b0);
        directed("right_col19",  623,   45, 3, 1'b0);
        directed("pillar_clear",  79,  100, 3, 1'b1);
        directed("pillar_hit",    80,  100, 3, 1'b0);
        directed("bottom_row14",  45,  463, 1, 1'b0);
        directed("offscreen_x", 1023,   45, 3, 1'b0);
        directed("offscreen_y",   45,  511, 1, 1'b0);
        directed("down_open2",    45,   45, 1, 1'b1);

        // Asynchronous reset mid-cycle must clear outputs before the next edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_result", result, 0);
        check("async_rst_clkdiv", clkdiv, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_result", result, 1);
        check("post_rst_clkdiv", clkdiv, 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                PacX = 10'($urandom_range(0, 1023));
                PacY = 9'($urandom_range(0, 511));
            end else begin
                PacX = 10'($urandom_range(0, 630));
                PacY = 9'($urandom_range(0, 470));
            end
            state = 2'($urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/maze_collision_check.md
Name: maze_collision_check

Overview:
- Decides each clock whether a 16x16 sprite at (PacX, PacY) can step one pixel in its current direction without entering a maze wall or leaving the 640x480 playfield.
- Also provides the free-running 32-bit clock-divider vector that ghost/pacman movers use as slow strobes (bit 17 for motion, bit 9 for turn decisions).
- Sits beside each mover: the mover steps while result=1 and picks a new direction while result=0.

Parameters:
- SPRITE, 16, sprite edge length in pixels (box spans x..x+SPRITE-1, y..y+SPRITE-1).
- TILE, 32, maze tile edge in pixels (power of two).
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- PacX  in  10  sprite top-left x.
- PacY  in  9  sprite top-left y.
- state  in  2  direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- result  out  1  1 = next step is free; 0 = blocked.
- clkdiv  out  32  free-running divider count.

Behaviour:
- clkdiv: +1 every clk rising edge; wraps 0xFFFFFFFF -> 0; async reset to 0.
- Next position: apply a one-pixel step to (PacX, PacY) per state.
  - Step below 0 (PacX=0 left, PacY=0 up) = blocked.
  - Computed in 11/10-bit width so it never wraps.
- Bounding box of next position: corners (nx, ny), (nx+SPRITE-1, ny), (nx, ny+SPRITE-1), (nx+SPRITE-1, ny+SPRITE-1).
- Any corner with x >= SCREEN_W or y >= SCREEN_H = blocked.
- Tile of a corner: col = x/TILE, row = y/TILE (shift). Grid is 20 cols x 15 rows.
- Wall map (package function is_wall(col,row)): wall if col==0 or col==19 or row==0 or row==14, or (col mod 4 == 3 and row mod 4 == 3).
  - Because SPRITE <= TILE, checking the four corners suffices.
- result = 1 only if all four corners are in-bounds and non-wall.
- result is registered: it reflects inputs sampled on the previous clk edge (latency 1 cycle). It updates every cycle with no enable or handshake.
- Reset: result=0 (blocked, so movers pick a direction first) and clkdiv=0. Reset asserted mid-operation clears both immediately, regardless of clk.
- Input changes between edges have no effect until the next edge. No other state exists.

Decomposition:
- Package maze_pkg:
  - direction encoding constants DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11;
  - TILE, grid size (20x15), SCREEN_W/H;
  - pure function is_wall(col,row).
- One sub-module, clock_divider: the 32-bit counter with async reset, instantiated inside maze_collision_check.
- Corner/tile logic stays inline.

Test Plan:
- rst=1 then released: result=0 and clkdiv=0 during reset. After release, clkdiv counts 1,2,3... one per clk, and clkdiv[9] first rises after 512 clocks.
- PacX=45, PacY=45, state=01 (down): next box y 46..61, all in tile (1,1) -> result=1 one clock later.
- PacX=45, PacY=32, state=00 (up): next y=31 falls in border row 0 -> result=0. Same position with state=10 and PacX=32: x=31 falls in col 0 -> result=0.
- PacX=0 or PacY=0 with left/up: no underflow wrap -> result=0. PacX=623, PacY=45, right: next x=624, box right edge 639 lies in col 19 (wall) -> result=0.
- Interior pillar at PacY=100, state=11 (right):
  - PacX=79: box x 80..95, col 2 -> result=1.
  - PacX=80: box right edge 96 in tile (3,3) -> result=0.
- Async reset pulse mid-run with PacX=45, PacY=45, state=01 and result=1: result drops to 0 and clkdiv to 0 without waiting for clk. result returns to 1 on the first edge after release.
